// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART (8N1) boot loader that streams a program into instruction memory
//
// Purpose: after a start pulse, receives a 16-bit little-endian word count N
// followed by N little-endian 32-bit words over uart_rx, and writes each word
// into instruction memory at consecutive word addresses starting at 0. The CPU
// is held in reset (cpu_hold) for the whole load.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   start       one-cycle pulse that begins a load (ignored while busy)
//   uart_rx     asynchronous serial input, idles high
//   imem_we     one-cycle instruction memory write strobe
//   imem_addr   byte address of the write (word aligned)
//   imem_wdata  instruction word being written
//   busy        load in progress
//   done        load completed successfully (sticky until next start)
//   err         load aborted (sticky until next start)
//   cpu_hold    copy of busy, drives the core's reset

module uart_program_loader #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int DIV   = CLK_FREQ / BAUD;
  localparam int HALF  = (DIV / 2 > 0) ? DIV / 2 : 1;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV + 1) : 1;
  // Largest word count that fits in the memory without wrapping the address.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** (ADDR_W - 2));

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

  state_t    state;
  rx_state_t rx_state;

  // ---------------------------------------------------------------------
  // Input synchronizer plus one extra stage for falling-edge detection
  // ---------------------------------------------------------------------
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             byte_valid;
  logic             framing_err;
  logic [7:0]       byte_data;
  logic             rx_en;

  assign rx_en     = (state == LEN0) || (state == LEN1) || (state == DATA);
  // rx_shift is only updated in RX_DATA, so it is stable while byte_valid is high.
  assign byte_data = rx_shift;

  always_ff @(posedge clk) begin
    byte_valid  <= 1'b0;
    framing_err <= 1'b0;
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else if (!rx_en) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          if (rx_prev && !rx_sync) rx_state <= RX_START;
        end
        RX_START: begin
          // Re-check the line half a bit later to reject glitches.
          if (rx_cnt == CNT_W'(HALF - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == CNT_W'(DIV - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == CNT_W'(DIV - 1)) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_sync) byte_valid  <= 1'b1;
            else         framing_err <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Load sequencer
  // ---------------------------------------------------------------------
  logic [7:0]  len_lo;
  logic [15:0] word_cnt;
  logic [1:0]  byte_idx;
  logic [15:0] len_word;

  assign len_word = {byte_data, len_lo};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_lo     <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done      <= 1'b0;
            err       <= 1'b0;
            imem_addr <= '0;
            busy      <= 1'b1;
            cpu_hold  <= 1'b1;
            state     <= LEN0;
          end
        end
        LEN0: begin
          if (framing_err) begin
            state <= ERR; busy <= 1'b0; cpu_hold <= 1'b0; err <= 1'b1;
          end else if (byte_valid) begin
            len_lo <= byte_data;
            state  <= LEN1;
          end
        end
        LEN1: begin
          if (framing_err) begin
            state <= ERR; busy <= 1'b0; cpu_hold <= 1'b0; err <= 1'b1;
          end else if (byte_valid) begin
            if (len_word == 16'd0) begin
              state <= DONE; busy <= 1'b0; cpu_hold <= 1'b0; done <= 1'b1;
            end else if ({1'b0, len_word} > MAX_WORDS) begin
              state <= ERR; busy <= 1'b0; cpu_hold <= 1'b0; err <= 1'b1;
            end else begin
              word_cnt <= len_word;
              byte_idx <= '0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (framing_err) begin
            state <= ERR; busy <= 1'b0; cpu_hold <= 1'b0; err <= 1'b1;
          end else if (byte_valid) begin
            imem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3) begin
              imem_we <= 1'b1;
              state   <= WRITE;
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt - 1'b1;
          if (word_cnt == 16'd1) begin
            // Last word: leave the address on it so it never steps past the
            // top of memory on a full-size load.
            state <= DONE; busy <= 1'b0; cpu_hold <= 1'b0; done <= 1'b1;
          end else begin
            imem_addr <= imem_addr + ADDR_W'(4);
            state     <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - self-checking bench for uart_program_loader

module tb_uart_program_loader;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int ADDR_W   = 14;
  localparam int DIV      = CLK_FREQ / BAUD;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              uart_rx;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              cpu_hold;

  uart_program_loader #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .uart_rx   (uart_rx),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  total = 0;
  int  bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      if (sb.size() == 0) begin
        check("we_unexpected", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        check("we_addr", 32'(imem_addr), e.addr);
        check("we_data", imem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
    wr_t e;
    e.addr = addr;
    e.data = w;
    sb.push_back(e);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_end(input logic exp_done, input logic exp_err);
    check("done", 32'(done), 32'(exp_done));
    check("err", 32'(err), 32'(exp_err));
    check("busy", 32'(busy), 32'd0);
    check("cpu_hold", 32'(cpu_hold), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(imem_we), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_flags", {28'd0, busy, done, err, cpu_hold}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal two-word load, with a start pulse mid-load that must be ignored.
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(32'h0, 32'h00000013);
    begin
      wr_t e;
      e.addr = 32'h4;
      e.data = 32'h00100093;
      sb.push_back(e);
    end
    send_byte(8'h93);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h10);
    send_byte(8'h00);
    check_end(1'b1, 1'b0);

    // Empty program.
    pulse_start();
    check("empty_done_cleared", 32'(done), 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    check_end(1'b1, 1'b0);

    // Framing error, then recovery.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'h55, 1'b0);
    check_end(1'b0, 1'b1);
    pulse_start();
    check("err_cleared", 32'(err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h0, 32'hDEADBEEF);
    check_end(1'b1, 1'b0);

    // False start during LEN0, then a valid load.
    pulse_start();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check("false_start_busy", 32'(busy), 32'd1);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h0, 32'hA5C3_0F81);
    check_end(1'b1, 1'b0);

    // Reset after five bytes, then a fresh load from address 0.
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_wdata", imem_wdata, 32'd0);
    check("midrst_addr", 32'(imem_addr), 32'd0);
    check("midrst_flags", {27'd0, imem_we, busy, done, err, cpu_hold}, 32'd0);
    @(negedge clk);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'h0, 32'h1234_5678);
    check_end(1'b1, 1'b0);

    // Oversize length: N = 0x1001 exceeds the 4096-word memory.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h10);
    check_end(1'b0, 1'b1);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
